wishbone_rr_arbiter: RTL

Round-robin grant controller for the shared Wishbone bus: decides which of `NUM_MASTER` masters owns the bus, holds ownership for the whole `cyc` burst, and counts outstanding pipelined requests. Its one-hot `gnt_o` replaces the fixed-priority grant in the shared-bus interconnect. A per-request watchdog terminates stuck transfers with an error.

---
 rtl/wishbone_pkg.sv | 19 +
 rtl/wishbone_rr_arbiter_rr_pick.sv | 43 ++++
 rtl/wishbone_rr_arbiter.sv | 135 +++++++++++++
 3 files changed

// File: rtl/wishbone_pkg.sv
// ============================================================================
// Module   : wishbone_pkg
// Brief    : Shared types and constants for the Wishbone bus arbitration logic.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package wishbone_pkg;

    localparam int OUTSTANDING_W = 4;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/wishbone_rr_arbiter_rr_pick.sv
// ============================================================================
// Module   : rr_pick
// Brief    : Combinational rotate-priority encoder, searching upward from
//            (last_idx + 1) modulo NUM_MASTER for the first active request.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick #(
    parameter int NUM_MASTER = 2,
    parameter int IDX_W      = (NUM_MASTER > 1) ? $clog2(NUM_MASTER) : 1
) (
    input  logic [NUM_MASTER-1:0] req_i,
    input  logic [IDX_W-1:0]      last_idx_i,
    output logic [NUM_MASTER-1:0] gnt_o,
    output logic [IDX_W-1:0]      idx_o
);

    int unsigned      w_pos;
    logic [IDX_W-1:0] w_cand;
    logic             w_found;

    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        w_found = 1'b0;
        w_pos   = 0;
        w_cand  = '0;
        // Offset NUM_MASTER wraps back to the last winner, so it loses every tie.
        for (int k = 1; k <= NUM_MASTER; k++) begin
            w_pos  = (int'(last_idx_i) + k) % NUM_MASTER;
            w_cand = IDX_W'(w_pos);
            if (!w_found && req_i[w_cand]) begin
                w_found       = 1'b1;
                gnt_o[w_cand] = 1'b1;
                idx_o         = w_cand;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/wishbone_rr_arbiter.sv
// ============================================================================
// Module   : wishbone_rr_arbiter
// Brief    : Round-robin Wishbone bus owner selection with outstanding-request
//            tracking and a per-request watchdog that forces an error.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wishbone_rr_arbiter
    import wishbone_pkg::*;
#(
    parameter int NUM_MASTER      = 2,
    parameter int MAX_OUTSTANDING = 4,
    parameter int TIMEOUT         = 255,
    parameter int IDX_W           = (NUM_MASTER > 1) ? $clog2(NUM_MASTER) : 1
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [NUM_MASTER-1:0]    cyc_i,
    input  logic                     stb_i,
    input  logic                     stall_i,
    input  logic                     ack_i,
    input  logic                     err_i,
    output logic [NUM_MASTER-1:0]    gnt_o,
    output logic [IDX_W-1:0]         gnt_idx_o,
    output logic                     busy_o,
    output logic                     stall_o,
    output logic                     timeout_err_o,
    output logic [OUTSTANDING_W-1:0] outstanding_o
);

    localparam int                       WDOG_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [OUTSTANDING_W-1:0] C_MAX     = OUTSTANDING_W'(MAX_OUTSTANDING);
    localparam logic [WDOG_W-1:0]        C_TIMEOUT = WDOG_W'(TIMEOUT);
    localparam logic                     C_WDOG_EN = (TIMEOUT != 0);

    arb_state_e               r_state;
    logic [NUM_MASTER-1:0]    r_gnt;
    logic [IDX_W-1:0]         r_gnt_idx;
    logic [IDX_W-1:0]         r_last_idx;
    logic [OUTSTANDING_W-1:0] r_count;
    logic [WDOG_W-1:0]        r_wdog;
    logic                     r_timeout_err;

    logic [NUM_MASTER-1:0]    w_pick_gnt;
    logic [IDX_W-1:0]         w_pick_idx;
    logic                     w_granted;
    logic                     w_owner_cyc;
    logic                     w_accept;
    logic                     w_dec;
    logic                     w_real_resp;
    logic                     w_expire;
    logic                     w_wdog_clr;

    rr_pick #(
        .NUM_MASTER (NUM_MASTER),
        .IDX_W      (IDX_W)
    ) u_rr_pick (
        .req_i      (cyc_i),
        .last_idx_i (r_last_idx),
        .gnt_o      (w_pick_gnt),
        .idx_o      (w_pick_idx)
    );

    assign w_granted   = (r_state == ST_GRANT);
    assign w_owner_cyc = cyc_i[r_gnt_idx];
    assign stall_o     = !w_granted || stall_i || (r_count == C_MAX);
    assign w_accept    = w_granted && stb_i && !stall_o;
    assign w_real_resp = ack_i || err_i;
    // A response with nothing outstanding is stray and must not underflow.
    assign w_dec       = (w_real_resp || r_timeout_err) && (r_count != '0);
    assign w_wdog_clr  = w_accept || w_real_resp || r_timeout_err || (r_count == '0);
    assign w_expire    = C_WDOG_EN && !w_wdog_clr && (r_wdog == C_TIMEOUT);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state       <= ST_IDLE;
            r_gnt         <= '0;
            r_gnt_idx     <= '0;
            r_last_idx    <= IDX_W'(NUM_MASTER - 1);
            r_count       <= '0;
            r_wdog        <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_count       <= '0;
                    r_wdog        <= '0;
                    r_timeout_err <= 1'b0;
                    if (|cyc_i) begin
                        r_state    <= ST_GRANT;
                        r_gnt      <= w_pick_gnt;
                        r_gnt_idx  <= w_pick_idx;
                        r_last_idx <= w_pick_idx;
                    end
                end
                ST_GRANT: begin
                    if (!w_owner_cyc) begin
                        // Owner abandoned its cycle: forget every pending request.
                        r_state       <= ST_IDLE;
                        r_gnt         <= '0;
                        r_count       <= '0;
                        r_wdog        <= '0;
                        r_timeout_err <= 1'b0;
                    end else begin
                        case ({w_accept, w_dec})
                            2'b10:   r_count <= r_count + 1'b1;
                            2'b01:   r_count <= r_count - 1'b1;
                            default: r_count <= r_count;
                        endcase
                        if (w_wdog_clr || w_expire || !C_WDOG_EN) begin
                            r_wdog <= '0;
                        end else begin
                            r_wdog <= r_wdog + 1'b1;
                        end
                        r_timeout_err <= w_expire;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_gnt   <= '0;
                end
            endcase
        end
    end

    assign gnt_o         = r_gnt;
    assign gnt_idx_o     = r_gnt_idx;
    assign busy_o        = w_granted;
    assign timeout_err_o = r_timeout_err;
    assign outstanding_o = r_count;

endmodule

`default_nettype wire
